// File: rtl/adpll_lock_det.sv
// ADPLL lock detector: measures reference period, feedback phase and edge count
// per reference window, and runs a hysteretic lock FSM on the results.
module adpll_lock_det #(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 2,
    parameter int CODE_TOL     = 1
) (
    input  logic             vco_clk,
    input  logic             reset,
    input  logic             ref_in,
    input  logic             fb_in,
    input  logic [3:0]       code_in,
    input  logic             clr_sticky,
    output logic             locked,
    output logic             lost_lock,
    output logic             ref_lost,
    output logic             meas_valid,
    output logic [CNT_W-1:0] ref_period,
    output logic [CNT_W-1:0] fb_phase,
    output logic [2:0]       fb_count,
    output logic [1:0]       lock_state
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2,
        SLIPPING = 2'd3
    } state_t;

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int BW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] ref_sync, fb_sync;
    logic                   ref_dly, fb_dly;
    logic                   ref_rise, fb_rise;
    logic [CNT_W-1:0]       period_cnt, phase_lat;
    logic                   phase_ok;
    logic [2:0]             win_cnt;
    logic [3:0]             code_prev;
    logic [4:0]             code_delta;
    logic                   first_window, eval, sat_hit, good;
    state_t                 state, state_nx;
    logic [GW-1:0]          good_cnt, good_nx;
    logic [BW-1:0]          bad_cnt, bad_nx;
    logic                   set_lost, locked_nx, lost_nx;

    always_ff @(posedge vco_clk) begin
        if (!reset) begin
            ref_sync <= '0;
            fb_sync  <= '0;
            ref_dly  <= 1'b0;
            fb_dly   <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[SYNC_STAGES-2:0], ref_in};
            fb_sync  <= {fb_sync[SYNC_STAGES-2:0], fb_in};
            ref_dly  <= ref_sync[SYNC_STAGES-1];
            fb_dly   <= fb_sync[SYNC_STAGES-1];
        end
    end

    assign ref_rise = ref_sync[SYNC_STAGES-1] & ~ref_dly;
    assign fb_rise  = fb_sync[SYNC_STAGES-1] & ~fb_dly;
    assign ref_lost = (period_cnt == CNT_MAX);
    assign sat_hit  = !ref_rise && (period_cnt == CNT_MAX - 1'b1);
    assign eval     = ref_rise & ~first_window;

    // Phase is the period count at the first fb edge; an fb edge on ref_rise starts the new window at 0.
    always_ff @(posedge vco_clk) begin
        if (!reset) begin
            period_cnt <= '0;
            phase_lat  <= '0;
            phase_ok   <= 1'b0;
            win_cnt    <= '0;
        end else if (ref_rise) begin
            period_cnt <= CNT_W'(1);
            phase_lat  <= '0;
            phase_ok   <= fb_rise;
            win_cnt    <= {2'b00, fb_rise};
        end else begin
            if (period_cnt != CNT_MAX)
                period_cnt <= period_cnt + 1'b1;
            if (fb_rise) begin
                if (win_cnt != 3'd7)
                    win_cnt <= win_cnt + 1'b1;
                if (!phase_ok) begin
                    phase_ok  <= 1'b1;
                    phase_lat <= period_cnt;
                end
            end
        end
    end

    always_comb begin
        if (code_in >= code_prev)
            code_delta = {1'b0, code_in} - {1'b0, code_prev};
        else
            code_delta = {1'b0, code_prev} - {1'b0, code_in};
        good = (win_cnt == 3'd1) && (int'(code_delta) <= CODE_TOL);
    end

    always_ff @(posedge vco_clk) begin
        if (!reset) begin
            meas_valid   <= 1'b0;
            ref_period   <= '0;
            fb_phase     <= '0;
            fb_count     <= '0;
            code_prev    <= '0;
            first_window <= 1'b1;
        end else begin
            meas_valid <= eval;
            if (ref_rise) begin
                code_prev    <= code_in;
                first_window <= 1'b0;
            end else if (sat_hit) begin
                first_window <= 1'b1;
            end
            if (eval) begin
                ref_period <= period_cnt;
                fb_phase   <= phase_ok ? phase_lat : '1;
                fb_count   <= win_cnt;
            end
        end
    end

    always_ff @(posedge vco_clk) begin
        if (!reset) begin
            state     <= UNLOCKED;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            state     <= state_nx;
            good_cnt  <= good_nx;
            bad_cnt   <= bad_nx;
            locked    <= locked_nx;
            lost_lock <= lost_nx;
        end
    end

    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        bad_nx   = bad_cnt;
        set_lost = 1'b0;
        if (sat_hit) begin
            state_nx = UNLOCKED;
            good_nx  = '0;
            bad_nx   = '0;
            set_lost = (state == LOCKED) || (state == SLIPPING);
        end else if (eval) begin
            case (state)
                UNLOCKED: if (good) begin
                    if (LOCK_COUNT == 1) begin
                        state_nx = LOCKED;
                        good_nx  = '0;
                    end else begin
                        state_nx = LOCKING;
                        good_nx  = GW'(1);
                    end
                end
                LOCKING: if (!good) begin
                    state_nx = UNLOCKED;
                    good_nx  = '0;
                end else if (int'(good_cnt) + 1 >= LOCK_COUNT) begin
                    state_nx = LOCKED;
                    good_nx  = '0;
                end else begin
                    good_nx = good_cnt + 1'b1;
                end
                LOCKED: if (!good) begin
                    if (UNLOCK_COUNT == 1) begin
                        state_nx = UNLOCKED;
                        set_lost = 1'b1;
                    end else begin
                        state_nx = SLIPPING;
                        bad_nx   = BW'(1);
                    end
                end
                SLIPPING: if (good) begin
                    state_nx = LOCKED;
                    bad_nx   = '0;
                end else if (int'(bad_cnt) + 1 >= UNLOCK_COUNT) begin
                    state_nx = UNLOCKED;
                    bad_nx   = '0;
                    set_lost = 1'b1;
                end else begin
                    bad_nx = bad_cnt + 1'b1;
                end
                default: state_nx = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        locked_nx = (state_nx == LOCKED) || (state_nx == SLIPPING);
        if (set_lost)
            lost_nx = 1'b1;
        else if (clr_sticky)
            lost_nx = 1'b0;
        else
            lost_nx = lost_lock;
    end

    assign lock_state = state;

endmodule

// File: tb/tb_adpll_lock_det.sv
// Directed bench for adpll_lock_det: one row per 100-cycle reference window,
// plus hand-written reference-loss and mid-lock reset sequences.
module tb_adpll_lock_det;

    logic        clk = 1'b0;
    logic        reset, ref_in, fb_in, clr_sticky;
    logic [3:0]  code_in;

    logic        locked, lost_lock, ref_lost, meas_valid;
    logic [15:0] ref_period, fb_phase;
    logic [2:0]  fb_count;
    logic [1:0]  lock_state;

    logic        locked_8, lost_lock_8, ref_lost_8, meas_valid_8;
    logic [7:0]  ref_period_8, fb_phase_8;
    logic [2:0]  fb_count_8;
    logic [1:0]  lock_state_8;

    always #5 clk = ~clk;

    adpll_lock_det #(.SYNC_STAGES(2), .CNT_W(16), .LOCK_COUNT(8), .UNLOCK_COUNT(2), .CODE_TOL(1)) dut (
        .vco_clk(clk), .reset(reset), .ref_in(ref_in), .fb_in(fb_in), .code_in(code_in),
        .clr_sticky(clr_sticky), .locked(locked), .lost_lock(lost_lock), .ref_lost(ref_lost),
        .meas_valid(meas_valid), .ref_period(ref_period), .fb_phase(fb_phase),
        .fb_count(fb_count), .lock_state(lock_state));

    adpll_lock_det #(.SYNC_STAGES(2), .CNT_W(8), .LOCK_COUNT(8), .UNLOCK_COUNT(2), .CODE_TOL(1)) dut8 (
        .vco_clk(clk), .reset(reset), .ref_in(ref_in), .fb_in(fb_in), .code_in(code_in),
        .clr_sticky(clr_sticky), .locked(locked_8), .lost_lock(lost_lock_8), .ref_lost(ref_lost_8),
        .meas_valid(meas_valid_8), .ref_period(ref_period_8), .fb_phase(fb_phase_8),
        .fb_count(fb_count_8), .lock_state(lock_state_8));

    typedef struct {
        int n_fb;  int off1; int off2; int code; bit clr;
        int e_mv;  int e_per; int e_ph; int e_cnt;
        int e_st;  int e_lk;  int e_lost;
    } row_t;

    row_t rows[41];
    int n_cmp = 0;
    int n_bad = 0;
    int mv_cnt, mv8_cnt, got_per, got_ph, got_cnt;

    function automatic row_t mk(input int n_fb, input int off1, input int code, input bit clr,
                                input int mv, input int per, input int ph, input int cnt,
                                input int st, input int lk, input int lost);
        row_t r;
        r.n_fb = n_fb; r.off1 = off1; r.off2 = 60; r.code = code; r.clr = clr;
        r.e_mv = mv; r.e_per = per; r.e_ph = ph; r.e_cnt = cnt;
        r.e_st = st; r.e_lk = lk; r.e_lost = lost;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one reference window; the measurement seen inside it describes the previous window.
    task automatic run_window(input int idx, input bit do_check);
        row_t r;
        r = rows[idx];
        mv_cnt = 0; mv8_cnt = 0; got_per = 0; got_ph = 0; got_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            ref_in     = (c < 50);
            fb_in      = (r.n_fb >= 1 && c >= r.off1 && c < r.off1 + 10) ||
                         (r.n_fb >= 2 && c >= r.off2 && c < r.off2 + 10);
            code_in    = 4'(r.code);
            clr_sticky = r.clr && (c == 80);
            tick();
            if (meas_valid) begin
                mv_cnt++;
                got_per = int'(ref_period);
                got_ph  = int'(fb_phase);
                got_cnt = int'(fb_count);
            end
            if (meas_valid_8) mv8_cnt++;
        end
        clr_sticky = 1'b0;
        if (do_check) begin
            check($sformatf("row%0d meas_valid count", idx), mv_cnt, r.e_mv);
            if (r.e_mv != 0) begin
                check($sformatf("row%0d ref_period", idx), got_per, r.e_per);
                check($sformatf("row%0d fb_phase", idx), got_ph, r.e_ph);
                check($sformatf("row%0d fb_count", idx), got_cnt, r.e_cnt);
            end
            check($sformatf("row%0d lock_state", idx), int'(lock_state), r.e_st);
            check($sformatf("row%0d locked", idx), int'(locked), r.e_lk);
            check($sformatf("row%0d lost_lock", idx), int'(lost_lock), r.e_lost);
        end
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) run_window(i, 1'b1);
    endtask

    initial begin
        int found, early;
        rows[0] = mk(1, 30, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) rows[i] = mk(1, 30, 8, 0, 1, 100, 30, 1, 1, 0, 0);
        rows[8]  = mk(1, 30, 8, 0, 1, 100, 30, 1, 2, 1, 0);
        rows[9]  = mk(1, 30, 11, 0, 1, 100, 30, 1, 3, 1, 0);
        rows[10] = mk(1, 30, 8, 0, 1, 100, 30, 1, 0, 0, 1);
        rows[11] = mk(1, 0, 8, 1, 1, 100, 30, 1, 1, 0, 0);
        rows[12] = mk(0, 0, 8, 0, 1, 100, 0, 1, 1, 0, 0);
        rows[13] = mk(1, 30, 8, 0, 1, 100, 65535, 0, 0, 0, 0);
        for (int i = 14; i <= 20; i++) rows[i] = mk(1, 30, 8, 0, 1, 100, 30, 1, 1, 0, 0);
        rows[21] = mk(1, 30, 8, 0, 1, 100, 30, 1, 2, 1, 0);
        rows[22] = mk(2, 30, 8, 0, 1, 100, 30, 1, 2, 1, 0);
        rows[23] = mk(1, 30, 8, 0, 1, 100, 30, 2, 3, 1, 0);
        rows[24] = mk(1, 30, 8, 0, 1, 100, 30, 1, 2, 1, 0);
        rows[25] = mk(1, 30, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 26; i <= 30; i++) rows[i] = mk(1, 30, 8, 0, 1, 100, 30, 1, 1, 0, 0);
        rows[31] = mk(1, 30, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 32; i <= 38; i++) rows[i] = mk(1, 30, 8, 0, 1, 100, 30, 1, 1, 0, 0);
        rows[39] = mk(1, 30, 8, 0, 1, 100, 30, 1, 2, 1, 0);
        rows[40] = mk(1, 30, 8, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b0; ref_in = 1'b0; fb_in = 1'b0; code_in = 4'd8; clr_sticky = 1'b0;
        repeat (5) tick();
        check("reset outputs zero",
              int'({locked, lost_lock, ref_lost, meas_valid, ref_period, fb_phase, fb_count, lock_state} != '0), 0);
        reset = 1'b1;

        run_rows(0, 24);

        // Reference stops: only the 8-bit instance can saturate within the bound.
        ref_in = 1'b0; fb_in = 1'b0;
        found = 0; early = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (i == 100) early = int'(ref_lost_8);
            if (ref_lost_8) begin
                found = 1;
                break;
            end
        end
        check("ref_lost8 asserted within bound", found, 1);
        check("ref_lost8 not early", early, 0);
        check("ref loss lock_state8", int'(lock_state_8), 0);
        check("ref loss locked8", int'(locked_8), 0);
        check("ref loss lost_lock8", int'(lost_lock_8), 1);
        check("ref_lost16 stays low", int'(ref_lost), 0);
        run_window(40, 1'b0);
        check("first edge after loss meas_valid8", mv8_cnt, 0);
        check("ref_lost8 cleared by ref edge", int'(ref_lost_8), 0);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        run_rows(25, 30);
        reset = 1'b0;
        tick();
        check("mid-LOCKING reset outputs zero",
              int'({locked, lost_lock, ref_lost, meas_valid, ref_period, fb_phase, fb_count, lock_state} != '0), 0);
        check("mid-LOCKING reset outputs zero (8)",
              int'({locked_8, lost_lock_8, ref_lost_8, meas_valid_8, ref_period_8, fb_phase_8, fb_count_8, lock_state_8} != '0), 0);
        reset = 1'b1;
        run_rows(31, 39);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
